// File: rtl/ibex_dmem_sram_bridge_pkg.sv
// Shared types and helpers for the Ibex data-side SRAM bridge.
// Holds the response record carried through the latency pipe and the byte-enable expansion.
package ibex_dmem_bridge_pkg;

    localparam int unsigned SRAM_LAT_MAX = 3;

    // is_write lets write responses return zero data without re-decoding the request.
    typedef struct packed {
        logic valid;
        logic err;
        logic is_write;
    } resp_t;

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{be[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/ibex_dmem_sram_bridge_if.sv
// Core LSU and SRAM-side signal bundle for the data bridge.
// The master modport is the environment (core + arbitrated SRAM); slave is the bridge.
interface ibex_dmem_sram_bridge_if #(
    parameter int unsigned AddrWidth   = 14,
    parameter int unsigned ErrCntWidth = 8
);
    logic                   data_req;
    logic                   data_gnt;
    logic                   data_rvalid;
    logic                   data_we;
    logic [3:0]             data_be;
    logic [31:0]            data_addr;
    logic [31:0]            data_wdata;
    logic [6:0]             data_wdata_intg;
    logic [31:0]            data_rdata;
    logic [6:0]             data_rdata_intg;
    logic                   data_err;

    logic                   sram_req;
    logic                   sram_gnt;
    logic                   sram_we;
    logic [AddrWidth-1:0]   sram_addr;
    logic [31:0]            sram_wmask;
    logic [31:0]            sram_wdata;
    logic [31:0]            sram_rdata;

    logic                   intg_err;
    logic [ErrCntWidth-1:0] err_count;

    modport master (
        output data_req, data_we, data_be, data_addr, data_wdata, data_wdata_intg,
        output sram_gnt, sram_rdata,
        input  data_gnt, data_rvalid, data_rdata, data_rdata_intg, data_err,
        input  sram_req, sram_we, sram_addr, sram_wmask, sram_wdata,
        input  intg_err, err_count
    );

    modport slave (
        input  data_req, data_we, data_be, data_addr, data_wdata, data_wdata_intg,
        input  sram_gnt, sram_rdata,
        output data_gnt, data_rvalid, data_rdata, data_rdata_intg, data_err,
        output sram_req, sram_we, sram_addr, sram_wmask, sram_wdata,
        output intg_err, err_count
    );

endinterface

// File: rtl/ibex_dmem_resp_pipe.sv
// Fixed-depth response shift register; the output stage lines up with SRAM read data.
module ibex_dmem_resp_pipe
    import ibex_dmem_bridge_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  resp_t resp_i,
    output resp_t resp_o
);

    // Depth outside 1..SRAM_LAT_MAX is not a supported SRAM; clamp rather than build nonsense.
    localparam int Stages = (Depth < 1) ? 1 :
                            (Depth > SRAM_LAT_MAX) ? int'(SRAM_LAT_MAX) : int'(Depth);

    resp_t stage_q [Stages];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Stages; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= resp_i;
            for (int i = 1; i < Stages; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign resp_o = stage_q[Stages-1];

endmodule

// File: rtl/prim_secded_inv_39_32_enc.sv
// Inverted Hsiao 39/32 SECDED encoder: data passes through, 7 check bits appended.
module prim_secded_inv_39_32_enc (
    input  logic [31:0] data_i,
    output logic [38:0] data_o
);

    logic [6:0] parity;

    assign parity[0] = ^(data_i & 32'h2606_BD25);
    assign parity[1] = ^(data_i & 32'hDEBA_8050);
    assign parity[2] = ^(data_i & 32'h413D_89AA);
    assign parity[3] = ^(data_i & 32'h3123_4ED1);
    assign parity[4] = ^(data_i & 32'hC2C1_323B);
    assign parity[5] = ^(data_i & 32'h2DCC_624C);
    assign parity[6] = ^(data_i & 32'h9850_5586);

    // Inversion keeps the all-zero codeword illegal.
    assign data_o = {parity ^ 7'h2A, data_i};

endmodule

// File: rtl/ibex_dmem_sram_bridge.sv
// Terminates the Ibex LSU req/gnt/rvalid protocol onto one arbitrated single-port SRAM,
// with write-integrity checking, read-integrity generation and in-order error responses.
module ibex_dmem_sram_bridge
    import ibex_dmem_bridge_pkg::*;
#(
    parameter int unsigned AddrWidth   = 14,
    parameter logic [31:0] BaseAddr    = 32'h0010_0000,
    parameter int unsigned SramLatency = 1,
    parameter int unsigned ErrCntWidth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    ibex_dmem_sram_bridge_if.slave bus
);

    localparam logic [31:0] WinMask = 32'((64'd4 << AddrWidth) - 64'd1);

    logic                   hit;
    logic                   intg_bad;
    logic                   sram_path;
    logic                   gnt;
    logic                   sram_req;
    logic [38:0]            wdata_enc;
    logic [38:0]            rdata_enc;
    logic [31:0]            rdata_gated;
    resp_t                  resp_in;
    resp_t                  resp_out;
    logic                   rvalid;
    logic                   intg_err_q;
    logic [ErrCntWidth-1:0] err_cnt_q;

    prim_secded_inv_39_32_enc u_wdata_enc (
        .data_i (bus.data_wdata),
        .data_o (wdata_enc)
    );

    assign hit       = (bus.data_addr & ~WinMask) == BaseAddr;
    assign intg_bad  = hit & bus.data_we &
                       (wdata_enc != {bus.data_wdata_intg, bus.data_wdata});
    assign sram_path = hit & ~intg_bad;

    // Misses and corrupted writes are granted locally so the SRAM never sees them.
    always_comb begin
        gnt      = 1'b0;
        sram_req = 1'b0;
        if (!rst_i && bus.data_req) begin
            if (sram_path) begin
                sram_req = 1'b1;
                gnt      = bus.sram_gnt;
            end else begin
                gnt      = 1'b1;
            end
        end
    end

    assign bus.data_gnt   = gnt;
    assign bus.sram_req   = sram_req;
    assign bus.sram_we    = bus.data_we;
    assign bus.sram_addr  = bus.data_addr[AddrWidth+1:2];
    assign bus.sram_wmask = be_to_mask(bus.data_be);
    assign bus.sram_wdata = bus.data_wdata;

    assign resp_in = gnt ? '{valid: 1'b1, err: ~sram_path, is_write: bus.data_we} : '0;

    ibex_dmem_resp_pipe #(
        .Depth (SramLatency)
    ) u_resp_pipe (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .resp_i (resp_in),
        .resp_o (resp_out)
    );

    // Gating with reset keeps a response that is mid-flight from leaking out in the reset cycle.
    assign rvalid      = resp_out.valid & ~rst_i;
    assign rdata_gated = (resp_out.err | resp_out.is_write) ? 32'h0 : bus.sram_rdata;

    prim_secded_inv_39_32_enc u_rdata_enc (
        .data_i (rdata_gated),
        .data_o (rdata_enc)
    );

    assign bus.data_rvalid     = rvalid;
    assign bus.data_err        = resp_out.err;
    assign bus.data_rdata      = rdata_enc[31:0];
    assign bus.data_rdata_intg = rdata_enc[38:32];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            intg_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            intg_err_q <= gnt & intg_bad;
            if (rvalid && resp_out.err && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign bus.intg_err  = rst_i ? 1'b0 : intg_err_q;
    assign bus.err_count = rst_i ? '0 : err_cnt_q;

endmodule
